proc_hazard_scoreboard: RTL and testbench
=========================================

Name: proc_hazard_scoreboard

Overview:
- Parametrised hazard unit for the in-order TinyRV pipeline; sits beside the processor control unit in D.
- Tracks destination registers of in-flight instructions in a DEPTH-entry shift scoreboard (entry 0 = X, entry DEPTH-1 = W).
- Produces per-operand bypass selects, load-use/long-latency stalls, and branch/jump squashes.
- Keeps saturating stall and squash performance counters.

Parameters:
- DEPTH, 3, post-D stages tracked (X..W); must be >=1.
- NREGS, 32, architectural registers; AW = $clog2(NREGS).
- CNT_W, 32, perf counter width.
- SW (localparam), $clog2(DEPTH+1), width of bypass selects and rdy_D.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- val_D  in  1  D holds a valid instruction.
- rs1_en_D  in  1  D reads rs1.
- rs2_en_D  in  1  D reads rs2.
- rs1_D  in  AW  rs1 index.
- rs2_D  in  AW  rs2 index.
- rf_wen_D  in  1  D instruction writes RF.
- waddr_D  in  AW  destination index.
- rdy_D  in  SW  first entry index whose result is bypassable (0 = ALU, 1 = load, etc.).
- jump_D  in  1  D is JAL/JR.
- br_taken_X  in  1  taken branch resolved in X, pre-qualified by caller.
- op1_byp_sel_D  out  SW  0 = RF, k = bypass from entry k-1.
- op2_byp_sel_D  out  SW  same for rs2.
- stall_F  out  1  hold F.
- stall_D  out  1  hold D, bubble into X.
- squash_F  out  1  kill F.
- squash_D  out  1  kill D.
- stall_cnt  out  CNT_W  cycles with stall_D=1.
- squash_cnt  out  CNT_W  cycles with squash_F=1.

Behaviour:
- Scoreboard entry e[i] holds {v, waddr, rdy}.
- Every cycle: e[i] <= e[i-1] for i>=1. The old e[DEPTH-1] retires.
- e[0] <= {ins, waddr_D, rdy_D}.
- ins = val_D & rf_wen_D & (waddr_D!=0) & ~stall_D & ~squash_D.
- x0 is never tracked.
- Match rs1 at i: val_D & rs1_en_D & e[i].v & (e[i].waddr==rs1_D). rs2 is analogous.
- Only the youngest (lowest i) match counts. Older matches are ignored.
- If youngest match has i >= e[i].rdy: sel = i+1, no hazard.
- If youngest match has i < e[i].rdy: hazard, sel = 0.
- rdy >= DEPTH: the operand is never bypassable; stall until the entry retires.
- No match: sel = 0.
- squash_D = br_taken_X.
- stall_D = (haz1 | haz2) & ~squash_D. Squash beats stall.
- stall_F = stall_D.
- squash_F = squash_D | (val_D & jump_D & ~stall_D). A stalled jump does not squash F until the stall clears.
- All outputs are combinational from the scoreboard and D inputs; there is no added latency.
- Counters increment by 1 per qualifying cycle and saturate at all-ones.
- Reset (rst=0 at a clk edge): all e[i].v=0 and both counters 0.
  - Outputs are then 0 for any D inputs, except squash_F/squash_D, which still follow br_taken_X/jump_D.
- Reset mid-operation discards all in-flight entries; there is no partial retire.

Optional Feature:
- Macro: PROC_HAZARD_BYPASS_EN.
- Defined: bypass behaviour as above.
- Undefined: op1/op2_byp_sel_D are tied to 0. Any match at any entry is a hazard (stall until the producer retires past W). rdy_D is ignored.
- Squash and counter behaviour are unchanged in both modes.

Test Plan:
- Reset: hold rst=0 two cycles with val_D=1, rs1_D=5 -> all sels 0, stall_D=0, counters 0.
- ALU chain:
  - D writes x5 with rdy=0, then D reads rs1=x5 over three consecutive cycles -> op1_byp_sel_D = 1, 2, 3, then 0; no stall.
  - Without the macro: stall_D=1 for 3 cycles, stall_cnt=3.
- Load-use: D writes x7 with rdy=1, next D reads rs2=x7 -> stall_D=stall_F=1 for one cycle, then op2_byp_sel_D=2; stall_cnt=1.
- Youngest wins: back-to-back writes x3 (rdy=0), then a read of x3 -> sel=1, not 2.
  - With the young writer rdy=1 -> stall even though the older entry is bypassable.
- Squash vs stall: load-use hazard in D with br_taken_X=1 -> squash_D=1, squash_F=1, stall_D=0; the next cycle e[0].v=0; squash_cnt +1.
- Jump/x0:
  - jump_D=1 with a load-use hazard on rs1 -> squash_F=0 while stalled, then 1 the next cycle.
  - waddr_D=0 writer -> the following read of x0 gives sel=0.

Source files
------------

// File: rtl/proc_hazard_scoreboard.sv
// Hazard unit for the in-order TinyRV pipeline: shift scoreboard, bypass selects, stalls, squashes and perf counters.
// Optional macro PROC_HAZARD_BYPASS_EN enables bypassing; when undefined every RAW match stalls until the producer retires.
module proc_hazard_scoreboard #(
    parameter  int unsigned DEPTH = 3,
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned CNT_W = 32,
    localparam int unsigned AW    = $clog2(NREGS),
    localparam int unsigned SW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             val_D,
    input  logic             rs1_en_D,
    input  logic             rs2_en_D,
    input  logic [AW-1:0]    rs1_D,
    input  logic [AW-1:0]    rs2_D,
    input  logic             rf_wen_D,
    input  logic [AW-1:0]    waddr_D,
    input  logic [SW-1:0]    rdy_D,
    input  logic             jump_D,
    input  logic             br_taken_X,
    output logic [SW-1:0]    op1_byp_sel_D,
    output logic [SW-1:0]    op2_byp_sel_D,
    output logic             stall_F,
    output logic             stall_D,
    output logic             squash_F,
    output logic             squash_D,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic             r_v     [DEPTH];
    logic [AW-1:0]    r_waddr [DEPTH];
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    logic [DEPTH-1:0] w_match1;
    logic [DEPTH-1:0] w_match2;
    logic             w_haz1;
    logic             w_haz2;
    logic [SW-1:0]    w_sel1;
    logic [SW-1:0]    w_sel2;
    logic             w_ins;

    always_comb begin
        w_match1 = '0;
        w_match2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_match1[i] = val_D & rs1_en_D & r_v[i] & (r_waddr[i] == rs1_D);
            w_match2[i] = val_D & rs2_en_D & r_v[i] & (r_waddr[i] == rs2_D);
        end
    end

`ifdef PROC_HAZARD_BYPASS_EN
    logic [SW-1:0] r_rdy [DEPTH];

    // Returns {hazard, sel} for the youngest (lowest index) matching entry only.
    function automatic logic [SW:0] resolve(input logic [DEPTH-1:0] m);
        logic [SW:0] res;
        logic        found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (m[i] && !found) begin
                found = 1'b1;
                if (SW'(i) < r_rdy[i]) res = {1'b1, {SW{1'b0}}};
                else                   res = {1'b0, SW'(i + 1)};
            end
        end
        return res;
    endfunction

    always_comb begin
        {w_haz1, w_sel1} = resolve(w_match1);
        {w_haz2, w_sel2} = resolve(w_match2);
    end

    always_ff @(posedge clk) begin
        r_rdy[0] <= rdy_D;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            r_rdy[i] <= r_rdy[i-1];
        end
    end
`else
    logic w_unused_rdy;

    assign w_unused_rdy = ^rdy_D;

    always_comb begin
        w_haz1 = |w_match1;
        w_haz2 = |w_match2;
        w_sel1 = '0;
        w_sel2 = '0;
    end
`endif

    assign op1_byp_sel_D = w_sel1;
    assign op2_byp_sel_D = w_sel2;
    assign squash_D      = br_taken_X;
    assign stall_D       = (w_haz1 | w_haz2) & ~squash_D;
    assign stall_F       = stall_D;
    assign squash_F      = squash_D | (val_D & jump_D & ~stall_D);
    assign w_ins         = val_D & rf_wen_D & (waddr_D != '0) & ~stall_D & ~squash_D;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_v[i] <= 1'b0;
            end
        end else begin
            r_v[0] <= w_ins;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_v[i] <= r_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_waddr[0] <= waddr_D;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            r_waddr[i] <= r_waddr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (stall_D && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (squash_F && (r_squash_cnt != '1)) begin
                r_squash_cnt <= r_squash_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign squash_cnt = r_squash_cnt;

endmodule

// File: tb/tb_proc_hazard_scoreboard.sv
// Directed plus randomized bench for proc_hazard_scoreboard against a queue-style reference model.
module tb_proc_hazard_scoreboard;

    localparam int unsigned DEPTH = 3;
    localparam int unsigned NREGS = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned AW    = $clog2(NREGS);
    localparam int unsigned SW    = $clog2(DEPTH + 1);
    localparam int          CMAX  = (1 << CNT_W) - 1;
`ifdef PROC_HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             val_D, rs1_en_D, rs2_en_D, rf_wen_D, jump_D, br_taken_X;
    logic [AW-1:0]    rs1_D, rs2_D, waddr_D;
    logic [SW-1:0]    rdy_D;
    logic [SW-1:0]    op1_byp_sel_D, op2_byp_sel_D;
    logic             stall_F, stall_D, squash_F, squash_D;
    logic [CNT_W-1:0] stall_cnt, squash_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: one record per tracked age (0 = youngest).
    bit   m_v   [DEPTH];
    int   m_wa  [DEPTH];
    int   m_rdy [DEPTH];
    int   m_sc, m_qc;
    int   e_sel1, e_sel2;
    bit   e_stall, e_sqD, e_sqF;

    proc_hazard_scoreboard #(.DEPTH(DEPTH), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .val_D(val_D), .rs1_en_D(rs1_en_D), .rs2_en_D(rs2_en_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rf_wen_D(rf_wen_D), .waddr_D(waddr_D), .rdy_D(rdy_D),
        .jump_D(jump_D), .br_taken_X(br_taken_X), .op1_byp_sel_D(op1_byp_sel_D),
        .op2_byp_sel_D(op2_byp_sel_D), .stall_F(stall_F), .stall_D(stall_D),
        .squash_F(squash_F), .squash_D(squash_D), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void resolve(input bit en, input int rs, output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        if (!(val_D && en)) return;
        for (int k = 0; k < DEPTH; k++) begin
            if (m_v[k] && m_wa[k] == rs) begin
                if (BYP && k >= m_rdy[k]) sel = k + 1;
                else                      haz = 1'b1;
                return;
            end
        end
    endfunction

    function automatic void model_eval();
        bit h1, h2;
        resolve(rs1_en_D, int'(rs1_D), e_sel1, h1);
        resolve(rs2_en_D, int'(rs2_D), e_sel2, h2);
        e_sqD   = br_taken_X;
        e_stall = (h1 || h2) && !e_sqD;
        e_sqF   = e_sqD || (val_D && jump_D && !e_stall);
    endfunction

    function automatic void model_update();
        if (!rst) begin
            foreach (m_v[k]) m_v[k] = 1'b0;
            m_sc = 0;
            m_qc = 0;
            return;
        end
        if (e_stall && m_sc < CMAX) m_sc++;
        if (e_sqF && m_qc < CMAX) m_qc++;
        for (int k = DEPTH - 1; k > 0; k--) begin
            m_v[k]   = m_v[k-1];
            m_wa[k]  = m_wa[k-1];
            m_rdy[k] = m_rdy[k-1];
        end
        m_v[0]   = val_D && rf_wen_D && waddr_D != 0 && !e_stall && !e_sqD;
        m_wa[0]  = int'(waddr_D);
        m_rdy[0] = int'(rdy_D);
    endfunction

    task automatic step(input string tag);
        #1;
        model_eval();
        chk({tag, ":sel1"},   32'(op1_byp_sel_D), 32'(e_sel1));
        chk({tag, ":sel2"},   32'(op2_byp_sel_D), 32'(e_sel2));
        chk({tag, ":stallD"}, 32'(stall_D),       32'(e_stall));
        chk({tag, ":stallF"}, 32'(stall_F),       32'(e_stall));
        chk({tag, ":sqD"},    32'(squash_D),      32'(e_sqD));
        chk({tag, ":sqF"},    32'(squash_F),      32'(e_sqF));
        chk({tag, ":scnt"},   32'(stall_cnt),     32'(m_sc));
        chk({tag, ":qcnt"},   32'(squash_cnt),    32'(m_qc));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit v, input bit e1, input int r1, input bit e2, input int r2,
                         input bit we, input int wa, input int rdy, input bit jmp, input bit br);
        val_D = v; rs1_en_D = e1; rs1_D = AW'(r1); rs2_en_D = e2; rs2_D = AW'(r2);
        rf_wen_D = we; waddr_D = AW'(wa); rdy_D = SW'(rdy); jump_D = jmp; br_taken_X = br;
    endtask

    initial begin
        rst = 1'b0;
        drive(1, 1, 5, 0, 0, 1, 5, 0, 0, 0);
        @(posedge clk); model_update();
        @(posedge clk); model_update();
        #1;
        step("reset");
        chk("reset:sel1_zero", 32'(op1_byp_sel_D), 32'd0);
        chk("reset:stall_zero", 32'(stall_D), 32'd0);
        rst = 1'b1;

        // ALU chain on x5
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); step("alu_w");
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); step("alu_r1");
        step("alu_r2"); step("alu_r3"); step("alu_r4");

        // load-use on x7
        rst = 1'b0; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("rst2"); rst = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0); step("ld_w");
        drive(1, 0, 0, 1, 7, 0, 0, 0, 0, 0); step("ld_r1"); step("ld_r2");

        // youngest writer wins
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); step("yw_w1"); step("yw_w2");
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); step("yw_r");
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); step("yw_w3");
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0); step("yw_w4");
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); step("yw_r2"); step("yw_r3");

        // squash beats stall
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0); step("sq_w");
        drive(1, 0, 0, 1, 7, 1, 9, 0, 0, 1); step("sq_hz");
        drive(1, 0, 0, 1, 9, 0, 0, 0, 0, 0); step("sq_next");

        // stalled jump, then x0 writer
        drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0); step("jp_w");
        drive(1, 1, 9, 0, 0, 0, 0, 0, 1, 0); step("jp_stall"); step("jp_go");
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); step("x0_w");
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0); step("x0_r");

        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 49) != 0);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
